// File: rtl/if_id_skid.sv
// IF/ID skid buffer: two-entry in-order holding stage between fetch and decode.
// Outputs come straight from registers; killed fetches become NOP_IS bubbles.
module if_id_skid #(
  parameter int                PC_W       = 32,
  parameter int                IS_W       = 32,
  parameter logic [IS_W-1:0]   NOP_IS     = '0,
  parameter int                KILL_DELAY = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            up_valid,
  output logic            up_ready,
  input  logic [PC_W-1:0] up_pc,
  input  logic [IS_W-1:0] up_is,
  input  logic            up_kill,
  input  logic            flush,
  output logic            dn_valid,
  input  logic            dn_ready,
  output logic [PC_W-1:0] dn_pc,
  output logic [IS_W-1:0] dn_is,
  output logic [1:0]      occ
);

  logic [PC_W-1:0] head_pc;
  logic [IS_W-1:0] head_is;
  logic [PC_W-1:0] skid_pc;
  logic [IS_W-1:0] skid_is;
  logic [1:0]      cnt;
  logic            kill_pend;

  logic            push;
  logic            pop;
  logic            kill_now;
  logic [IS_W-1:0] in_is;

  assign up_ready = (cnt != 2'd2);
  assign dn_valid = (cnt != 2'd0);
  assign occ      = cnt;
  assign dn_pc    = head_pc;
  assign dn_is    = head_is;

  assign push = up_valid && up_ready;
  assign pop  = dn_valid && dn_ready;

  assign kill_now = (KILL_DELAY == 0) ? up_kill : kill_pend;
  assign in_is    = kill_now ? NOP_IS : up_is;

  // entry storage and occupancy; empty head always shows pc 0 / NOP
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cnt     <= 2'd0;
      head_pc <= '0;
      head_is <= NOP_IS;
      skid_pc <= '0;
      skid_is <= NOP_IS;
    end else begin
      unique case (cnt)
        2'd0: begin
          if (push) begin
            head_pc <= up_pc;
            head_is <= in_is;
            cnt     <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_pc <= up_pc;
            head_is <= in_is;
          end else if (push) begin
            skid_pc <= up_pc;
            skid_is <= in_is;
            cnt     <= 2'd2;
          end else if (pop) begin
            head_pc <= '0;
            head_is <= NOP_IS;
            cnt     <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head_pc <= skid_pc;
            head_is <= skid_is;
            skid_pc <= '0;
            skid_is <= NOP_IS;
            cnt     <= 2'd1;
          end
        end
        default: begin
          cnt <= 2'd0;
        end
      endcase
    end
  end

  // deferred kill: armed by any kill, consumed by the next accepted fetch
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      kill_pend <= 1'b0;
    end else if (KILL_DELAY != 0) begin
      if (push) kill_pend <= up_kill;
      else      kill_pend <= kill_pend | up_kill;
    end else begin
      kill_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_id_skid.sv
// Bench for if_id_skid: queue scoreboard over two instances,
// one with deferred kill and one with immediate kill.
module tb_if_id_skid;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] is;
  } ent_t;

  logic        clk;
  logic        rst;
  logic        up_valid;
  logic [31:0] up_pc;
  logic [31:0] up_is;
  logic        up_kill;
  logic        flush;
  logic        dn_ready;

  logic        up_ready [2];
  logic        dn_valid [2];
  logic [31:0] dn_pc    [2];
  logic [31:0] dn_is    [2];
  logic [1:0]  occ      [2];

  ent_t q [2][$];
  logic pend [2];
  logic armed;

  int n_chk;
  int n_fail;

  if_id_skid #(
    .PC_W(32), .IS_W(32), .NOP_IS(NOP), .KILL_DELAY(1)
  ) u_kd1 (
    .clk(clk), .rst(rst),
    .up_valid(up_valid), .up_ready(up_ready[0]),
    .up_pc(up_pc), .up_is(up_is), .up_kill(up_kill),
    .flush(flush),
    .dn_valid(dn_valid[0]), .dn_ready(dn_ready),
    .dn_pc(dn_pc[0]), .dn_is(dn_is[0]), .occ(occ[0])
  );

  if_id_skid #(
    .PC_W(32), .IS_W(32), .NOP_IS(NOP), .KILL_DELAY(0)
  ) u_kd0 (
    .clk(clk), .rst(rst),
    .up_valid(up_valid), .up_ready(up_ready[1]),
    .up_pc(up_pc), .up_is(up_is), .up_kill(up_kill),
    .flush(flush),
    .dn_valid(dn_valid[1]), .dn_ready(dn_ready),
    .dn_pc(dn_pc[1]), .dn_is(dn_is[1]), .occ(occ[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int k,
                     input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s inst=%0d t=%0t got=%h exp=%h",
               nm, k, $time, got, exp);
    end
  endtask

  // reference: a plain FIFO of what decode must see, capacity two
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst || flush) begin
        q[k].delete();
        pend[k] = 1'b0;
      end else begin
        int   sz;
        logic psh;
        logic pp;
        logic kl;
        ent_t e;
        sz  = q[k].size();
        psh = up_valid && (sz < 2);
        pp  = (sz > 0) && dn_ready;
        kl  = (k == 0) ? pend[k] : up_kill;
        e.pc = up_pc;
        e.is = kl ? NOP : up_is;
        if (pp) void'(q[k].pop_front());
        if (psh) q[k].push_back(e);
        if (k == 0) pend[k] = psh ? up_kill : (pend[k] | up_kill);
      end
    end
    if (rst) armed = 1'b1;
  end

  // monitor: compare what the DUT presents against the expected head
  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        int sz;
        sz = q[k].size();
        chk("occ", k, {30'd0, occ[k]}, sz);
        chk("dn_valid", k, {31'd0, dn_valid[k]}, {31'd0, sz != 0});
        chk("up_ready", k, {31'd0, up_ready[k]}, {31'd0, sz != 2});
        if (sz != 0) begin
          chk("dn_pc", k, dn_pc[k], q[k][0].pc);
          chk("dn_is", k, dn_is[k], q[k][0].is);
        end else begin
          chk("dn_pc_empty", k, dn_pc[k], 32'd0);
          chk("dn_is_empty", k, dn_is[k], NOP);
        end
      end
    end
  end

  task automatic drv(input logic v, input logic [31:0] pc,
                     input logic [31:0] is, input logic kl,
                     input logic fl, input logic dr, input logic r);
    @(negedge clk);
    #1;
    up_valid = v;
    up_pc    = pc;
    up_is    = is;
    up_kill  = kl;
    flush    = fl;
    dn_ready = dr;
    rst      = r;
  endtask

  task automatic idle(input logic dr);
    drv(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, dr, 1'b0);
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    armed    = 1'b0;
    pend[0]  = 1'b0;
    pend[1]  = 1'b0;
    rst      = 1'b1;
    up_valid = 1'b0;
    up_pc    = '0;
    up_is    = '0;
    up_kill  = 1'b0;
    flush    = 1'b0;
    dn_ready = 1'b0;

    drv(1'b1, 32'h99, 32'h1234, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(1'b1);

    // streaming
    drv(1'b1, 32'h0, 32'h0000_0101, 1'b0, 1'b0, 1'b1, 1'b0);
    drv(1'b1, 32'h4, 32'h0000_0202, 1'b0, 1'b0, 1'b1, 1'b0);
    drv(1'b1, 32'h8, 32'h0000_0303, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // backpressure: 0x18 stays offered until accepted
    drv(1'b1, 32'h10, 32'h0000_1010, 1'b0, 1'b0, 1'b0, 1'b0);
    drv(1'b1, 32'h14, 32'h0000_1414, 1'b0, 1'b0, 1'b0, 1'b0);
    drv(1'b1, 32'h18, 32'h0000_1818, 1'b0, 1'b0, 1'b0, 1'b0);
    drv(1'b1, 32'h18, 32'h0000_1818, 1'b0, 1'b0, 1'b1, 1'b0);
    drv(1'b1, 32'h18, 32'h0000_1818, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // delayed kill on an idle cycle, then two pushes
    drv(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    drv(1'b1, 32'h20, 32'h00A0_0093, 1'b0, 1'b0, 1'b1, 1'b0);
    drv(1'b1, 32'h24, 32'h0010_0113, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b1);

    // immediate kill, and kill coincident with a consuming push
    drv(1'b1, 32'h30, 32'h0020_0193, 1'b1, 1'b0, 1'b1, 1'b0);
    drv(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    drv(1'b1, 32'h34, 32'h0030_0213, 1'b1, 1'b0, 1'b1, 1'b0);
    drv(1'b1, 32'h38, 32'h0040_0293, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b1);

    // flush while full with a concurrent push
    drv(1'b1, 32'h3C, 32'h0000_3C3C, 1'b0, 1'b0, 1'b0, 1'b0);
    drv(1'b1, 32'h3E, 32'h0000_3E3E, 1'b0, 1'b0, 1'b0, 1'b0);
    drv(1'b1, 32'h40, 32'h0000_4040, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1'b1);

    // reset while full with a kill pending, plus flush
    drv(1'b1, 32'h50, 32'h0000_5050, 1'b0, 1'b0, 1'b0, 1'b0);
    drv(1'b1, 32'h54, 32'h0000_5454, 1'b0, 1'b0, 1'b0, 1'b0);
    drv(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    drv(1'b1, 32'h58, 32'h0000_5858, 1'b1, 1'b1, 1'b1, 1'b1);
    drv(1'b1, 32'h60, 32'h0000_6060, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drv($urandom_range(0, 3) != 0,
          {$urandom_range(0, 32'h3FFF), 2'b00},
          $urandom,
          $urandom_range(0, 4) == 0,
          $urandom_range(0, 40) == 0,
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 80) == 0);
    end
    idle(1'b1);
    idle(1'b1);
    @(negedge clk);
    #2;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_skid.md
IF_ID_SKID -- requirements
Module: if_id_skid

Interface
REQ-001 Parameter PC_W, default 32, fetch PC width.
REQ-002 Parameter IS_W, default 32, instruction width.
REQ-003 Parameter NOP_IS, default all-zero (IS_W bits), bubble encoding driven for killed/empty slots.
REQ-004 Parameter KILL_DELAY, default 1; 0 = kill applies to same-cycle accepted instruction, 1 = kill applies to next accepted instruction.
REQ-005 Reset rst, synchronous, active-high; clock clk.
REQ-006 Ports SHALL be:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- up_valid  in  1  fetch offers instruction
- up_ready  out  1  block can accept
- up_pc  in  PC_W  fetch PC
- up_is  in  IS_W  fetch instruction
- up_kill  in  1  instruction invalid (mispredict / mem not ok)
- flush  in  1  discard all held entries
- dn_valid  out  1  decode slot holds entry
- dn_ready  in  1  decode consumes
- dn_pc  out  PC_W  head PC
- dn_is  out  IS_W  head instruction
- occ  out  2  entries held (0..2)

Function
REQ-007 Block SHALL be a 2-entry in-order buffer (head + skid); all outputs SHALL be driven from registers only (no combinational in-to-out path).
REQ-008 Push SHALL occur on up_valid && up_ready; pop SHALL occur on dn_valid && dn_ready.
REQ-009 up_ready SHALL equal (occ != 2); dn_valid SHALL equal (occ != 0).
REQ-010 Latency: pushed entry into empty buffer SHALL appear on dn_* the cycle after push.
REQ-011 occ next: +1 on push only, -1 on pop only, unchanged on push+pop or neither.
REQ-012 Push+pop with occ=1: new entry SHALL become head next cycle, occ stays 1.
REQ-013 Pop with occ=2: skid entry SHALL move to head, occ=1; no push possible that cycle (up_ready=0).
REQ-014 Entries SHALL leave in push order; no entry duplicated or dropped except by flush.
REQ-015 KILL_DELAY=0: push with up_kill=1 SHALL store PC unchanged and instruction NOP_IS.
REQ-016 KILL_DELAY=1: internal kill_pend SHALL be set by up_kill=1 in any cycle; next push SHALL store NOP_IS and clear kill_pend; up_kill=1 in the same cycle as that push SHALL re-set kill_pend.
REQ-017 With KILL_DELAY=1 and no push, kill_pend SHALL hold.
REQ-018 Killed entries SHALL still count in occ and be presented with dn_valid=1.
REQ-019 When occ=0, dn_pc SHALL be 0 and dn_is SHALL be NOP_IS.
REQ-020 flush=1 SHALL set occ=0 next cycle, ignore any same-cycle push, clear kill_pend; a same-cycle pop is harmless.
REQ-021 flush and rst together: rst SHALL dominate (identical end state).

Reset
REQ-022 On rising clk with rst=1: occ=0, dn_valid=0, up_ready=1, dn_pc=0, dn_is=NOP_IS, kill_pend=0, skid contents cleared.
REQ-023 rst mid-operation SHALL discard all held entries; push/pop in that cycle SHALL be ignored.
REQ-024 All outputs SHALL reach reset values after exactly one clk edge with rst=1.

Verification
REQ-025 Streaming: dn_ready=1, push pc 0x0,0x4,0x8 back-to-back -> dn_pc 0x0,0x4,0x8 on consecutive cycles, occ=1 throughout, up_ready=1.
REQ-026 Backpressure: dn_ready=0, push 0x10,0x14 -> occ=2, up_ready=0, 0x18 held upstream; raise dn_ready -> order 0x10,0x14,0x18, no loss.
REQ-027 Delayed kill (KILL_DELAY=1): up_kill=1 idle cycle, then push pc 0x20 is 0x00A00093 -> dn_pc=0x20, dn_is=NOP_IS; following push shows real instruction.
REQ-028 Immediate kill (KILL_DELAY=0): push pc 0x30 with up_kill=1 -> dn_pc=0x30, dn_is=NOP_IS, dn_valid=1.
REQ-029 Flush with occ=2 plus concurrent push of 0x40 -> next cycle occ=0, dn_valid=0, dn_is=NOP_IS; 0x40 never emerges.
REQ-030 rst asserted with occ=2 and kill_pend=1 -> next cycle all REQ-022 values; first post-reset push not killed.
